data_mem: RTL and testbench



---
 rtl/data_mem_if.sv | 20 ++
 rtl/data_mem.sv | 48 ++++
 tb/tb_data_mem.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Load/store bus between the MEM stage and data_mem.
// addr_err exists only when DATA_MEM_RANGE_CHECK_EN is defined.
interface data_mem_if #(
   parameter int unsigned WORD_LEN = 32
);
   logic                writeEn;
   logic                readEn;
   logic [WORD_LEN-1:0] address;
   logic [WORD_LEN-1:0] dataIn;
   logic [WORD_LEN-1:0] dataOut;
`ifdef DATA_MEM_RANGE_CHECK_EN
   logic                addr_err;

   modport master (output writeEn, readEn, address, dataIn, input dataOut, addr_err);
   modport slave  (input writeEn, readEn, address, dataIn, output dataOut, addr_err);
`else
   modport master (output writeEn, readEn, address, dataIn, input dataOut);
   modport slave  (input writeEn, readEn, address, dataIn, output dataOut);
`endif
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory for the MEM stage: synchronous write, combinational read.
// Define DATA_MEM_RANGE_CHECK_EN to add addr_err and block out-of-range accesses.
module data_mem #(
   parameter int unsigned WORD_LEN  = 32,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned BASE_ADDR = 1024
) (
   input  logic      clk,
   input  logic      rst,
   data_mem_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [WORD_LEN-1:0] mem [DEPTH];
   logic [WORD_LEN-1:0] offset;
   logic [IDX_W-1:0]    index;
   logic                in_range;

   // Unsigned wrap makes addresses below BASE_ADDR land far above the window.
   assign offset = bus.address - WORD_LEN'(BASE_ADDR);
   assign index  = offset[IDX_W+1:2];

`ifdef DATA_MEM_RANGE_CHECK_EN
   assign in_range     = (offset < WORD_LEN'(4 * DEPTH));
   assign bus.addr_err = (bus.readEn | bus.writeEn) & ~in_range;
`else
   logic unused_bits;
   assign unused_bits = ^{offset[WORD_LEN-1:IDX_W+2], offset[1:0]};
   assign in_range    = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.writeEn && in_range) begin
         mem[index] <= bus.dataIn;
      end
   end

   always_comb begin
      bus.dataOut = '0;
      if (bus.readEn && in_range) begin
         bus.dataOut = mem[index];
      end
   end
endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus queues expectations, a negedge monitor checks them.
// Range-check cases run when DATA_MEM_RANGE_CHECK_EN is defined.
module tb_data_mem;
   typedef struct {
      string       name;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   logic chk;
   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   data_mem_if #(.WORD_LEN(32)) bus ();

   data_mem #(.WORD_LEN(32), .DEPTH(64), .BASE_ADDR(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic r, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic do_chk, input logic [31:0] ed,
                       input logic ee, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      bus.writeEn = we;
      bus.readEn  = re;
      bus.address = a;
      bus.dataIn  = d;
      chk         = do_chk;
      if (do_chk) begin
         e.name = nm;
         e.data = ed;
         e.err  = ee;
         sb.push_back(e);
      end
   endtask

   // Monitor: every cycle flagged by the stimulus is popped and compared.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_underflow: check flagged with empty scoreboard");
            end else begin
               e = sb.pop_front();
               n_cmp++;
               if (bus.dataOut !== e.data) begin
                  n_bad++;
                  $display("FAIL %s: dataOut got %h want %h", e.name, bus.dataOut, e.data);
               end
`ifdef DATA_MEM_RANGE_CHECK_EN
               n_cmp++;
               if (bus.addr_err !== e.err) begin
                  n_bad++;
                  $display("FAIL %s_err: addr_err got %b want %b", e.name, bus.addr_err, e.err);
               end
`endif
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      chk = 1'b0;
      rst = 1'b1;
      bus.writeEn = 1'b0;
      bus.readEn  = 1'b0;
      bus.address = '0;
      bus.dataIn  = '0;

      //   rst we re addr  data          chk exp          err name
      step(1, 0, 0, 1024, 32'h0,        0, 32'h0,        0, "rst0");
      step(1, 0, 0, 1024, 32'h0,        0, 32'h0,        0, "rst1");
      step(0, 0, 1, 1024, 32'h0,        1, 32'h0,        0, "reset_1024");
      step(0, 0, 1, 1028, 32'h0,        1, 32'h0,        0, "reset_1028");
      step(0, 0, 1, 1276, 32'h0,        1, 32'h0,        0, "reset_1276");

      step(0, 1, 0, 1024, 32'hDEADBEEF, 0, 32'h0,        0, "wr_1024");
      step(0, 1, 0, 1028, 32'h12345678, 0, 32'h0,        0, "wr_1028");
      step(0, 0, 1, 1024, 32'h0,        1, 32'hDEADBEEF, 0, "rd_1024");
      step(0, 0, 1, 1028, 32'h0,        1, 32'h12345678, 0, "rd_1028");
      step(0, 0, 0, 1024, 32'h0,        1, 32'h0,        0, "rd_disabled");

      step(0, 1, 1, 1032, 32'hA5A5A5A5, 1, 32'h0,        0, "wr_rd_same_before");
      step(0, 0, 1, 1032, 32'h0,        1, 32'hA5A5A5A5, 0, "wr_rd_same_after");

      step(0, 1, 0, 1036, 32'h11,       0, 32'h0,        0, "wr_1036");
      step(0, 0, 1, 1037, 32'h0,        1, 32'h11,       0, "rd_1037");
      step(0, 0, 1, 1038, 32'h0,        1, 32'h11,       0, "rd_1038");
      step(0, 0, 1, 1039, 32'h0,        1, 32'h11,       0, "rd_1039");

      step(1, 1, 0, 1040, 32'h55,       0, 32'h0,        0, "rst_with_wr");
      step(0, 0, 1, 1040, 32'h0,        1, 32'h0,        0, "rd_1040_after_rst");
      step(0, 0, 1, 1024, 32'h0,        1, 32'h0,        0, "rst_clears_1024");
      step(0, 0, 1, 1028, 32'h0,        1, 32'h0,        0, "rst_clears_1028");
      step(0, 0, 1, 1032, 32'h0,        1, 32'h0,        0, "rst_clears_1032");
      step(0, 0, 1, 1036, 32'h0,        1, 32'h0,        0, "rst_clears_1036");

`ifdef DATA_MEM_RANGE_CHECK_EN
      step(0, 1, 0, 1024, 32'h77,       1, 32'h0,        0, "rc_wr_1024");
      step(0, 1, 0, 1020, 32'h99,       1, 32'h0,        1, "rc_wr_1020");
      step(0, 1, 0, 1280, 32'h88,       1, 32'h0,        1, "rc_wr_1280");
      step(0, 0, 1, 1020, 32'h0,        1, 32'h0,        1, "rc_rd_1020");
      step(0, 0, 1, 1280, 32'h0,        1, 32'h0,        1, "rc_rd_1280");
      step(0, 0, 1, 1024, 32'h0,        1, 32'h77,       0, "rc_1024_unchanged");
      step(0, 0, 1, 1276, 32'h0,        1, 32'h0,        0, "rc_1276_unchanged");
      step(0, 0, 0, 1280, 32'h0,        1, 32'h0,        0, "rc_idle_no_err");
`else
      step(0, 1, 0, 1280, 32'h77,       0, 32'h0,        0, "wrap_wr_1280");
      step(0, 0, 1, 1024, 32'h0,        1, 32'h77,       0, "wrap_rd_1024");
      step(0, 0, 1, 1280, 32'h0,        1, 32'h77,       0, "wrap_rd_1280");
      step(0, 1, 0, 1020, 32'h99,       0, 32'h0,        0, "wrap_wr_1020");
      step(0, 0, 1, 1276, 32'h0,        1, 32'h99,       0, "wrap_rd_1276");
`endif

      step(0, 0, 0, 1024, 32'h0,        0, 32'h0,        0, "idle");
      @(posedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_leftover: %0d entries remain, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
